// File: rtl/imm_issue_ctrl_pkg.sv
// Shared definitions for the decode-stage immediate issue controller:
// opcode names, immediate length/extension codes, skid FSM states and
// the record held in each buffer slot.
package wisc_pkg;

  // Opcodes that carry an immediate field (instr[15:11]).
  localparam logic [4:0] J     = 5'b00100;
  localparam logic [4:0] JR    = 5'b00101;
  localparam logic [4:0] JAL   = 5'b00110;
  localparam logic [4:0] JALR  = 5'b00111;
  localparam logic [4:0] ADDI  = 5'b01000;
  localparam logic [4:0] SUBI  = 5'b01001;
  localparam logic [4:0] XORI  = 5'b01010;
  localparam logic [4:0] ANDNI = 5'b01011;
  localparam logic [4:0] BEQZ  = 5'b01100;
  localparam logic [4:0] BNEZ  = 5'b01101;
  localparam logic [4:0] BLTZ  = 5'b01110;
  localparam logic [4:0] BGEZ  = 5'b01111;
  localparam logic [4:0] ST    = 5'b10000;
  localparam logic [4:0] LD    = 5'b10001;
  localparam logic [4:0] SLBI  = 5'b10010;
  localparam logic [4:0] STU   = 5'b10011;
  localparam logic [4:0] ROLI  = 5'b10100;
  localparam logic [4:0] SLLI  = 5'b10101;
  localparam logic [4:0] RORI  = 5'b10110;
  localparam logic [4:0] SRLI  = 5'b10111;
  localparam logic [4:0] LBI   = 5'b11000;

  // Immediate field length selectors.
  localparam logic [1:0] LEN_5  = 2'b00;
  localparam logic [1:0] LEN_8  = 2'b01;
  localparam logic [1:0] LEN_11 = 2'b10;

  // Extension type.
  localparam logic EXT_SIGN = 1'b1;
  localparam logic EXT_ZERO = 1'b0;

  // Skid buffer occupancy.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_TWO   = 2'b10
  } state_t;

  // One buffered instruction with its already-extended immediate.
  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc;
    logic [15:0] imm;
    logic        used;
  } slot_t;

endpackage

// File: rtl/imm_issue_ctrl_if.sv
// Fetch-side and register-read-side handshake bundle of the issue controller.
//
// Both channels use strict valid/ready: a word transfers on a rising edge
// where valid and ready are both 1; once valid is raised the sender keeps it
// and its payload stable until the transfer happens, and valid never depends
// combinationally on ready.
interface imm_issue_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_instr;
  logic [15:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_instr;
  logic [15:0] out_pc;
  logic [15:0] out_imm;
  logic        out_imm_used;

  // Environment side: feeds fetch words and consumes issued words.
  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_instr, out_pc, out_imm, out_imm_used
  );

  // Controller side.
  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_instr, out_pc, out_imm, out_imm_used
  );
endinterface

// File: rtl/imm_issue_ctrl_decode.sv
// Opcode to immediate-control decode: whether an immediate is present,
// how it is extended and which field width it uses.
module imm_decode
  import wisc_pkg::*;
(
  input  logic [4:0] opcode,
  output logic       used,
  output logic       ext_type,
  output logic [1:0] length
);

  // Pure table lookup; unlisted opcodes carry no immediate.
  always_comb begin
    used     = 1'b0;
    ext_type = EXT_ZERO;
    length   = LEN_5;
    case (opcode)
      ADDI, SUBI, ST, LD, STU: begin
        used = 1'b1; ext_type = EXT_SIGN; length = LEN_5;
      end
      XORI, ANDNI, ROLI, SLLI, RORI, SRLI: begin
        used = 1'b1; ext_type = EXT_ZERO; length = LEN_5;
      end
      BEQZ, BNEZ, BLTZ, BGEZ, LBI, JR, JALR: begin
        used = 1'b1; ext_type = EXT_SIGN; length = LEN_8;
      end
      SLBI: begin
        used = 1'b1; ext_type = EXT_ZERO; length = LEN_8;
      end
      J, JAL: begin
        used = 1'b1; ext_type = EXT_SIGN; length = LEN_11;
      end
      default: begin
        used     = 1'b0;
        ext_type = EXT_ZERO;
        length   = LEN_5;
      end
    endcase
  end

endmodule

// File: rtl/imm_issue_ctrl_extender.sv
// Immediate extender: widens the low 5, 8 or 11 instruction bits to 16 bits
// with sign or zero fill. Output is forced to 0 when no immediate is used.
module extender
  import wisc_pkg::*;
(
  input  logic [10:0] field,
  input  logic        used,
  input  logic        ext_type,
  input  logic [1:0]  length,
  output logic [15:0] imm
);

  logic fill;

  // Select field width and fill bit; unused immediates read as zero.
  always_comb begin
    imm  = 16'h0000;
    fill = 1'b0;
    if (used) begin
      case (length)
        LEN_5: begin
          fill = (ext_type == EXT_SIGN) ? field[4] : 1'b0;
          imm  = {{11{fill}}, field[4:0]};
        end
        LEN_8: begin
          fill = (ext_type == EXT_SIGN) ? field[7] : 1'b0;
          imm  = {{8{fill}}, field[7:0]};
        end
        LEN_11: begin
          fill = (ext_type == EXT_SIGN) ? field[10] : 1'b0;
          imm  = {{5{fill}}, field[10:0]};
        end
        default: begin
          fill = 1'b0;
          imm  = 16'h0000;
        end
      endcase
    end
  end

endmodule

// File: rtl/imm_issue_ctrl.sv
// Decode-stage issue controller. Extends the immediate of each fetched word
// on the way in, then holds it in a two-entry skid buffer (main + skid) so
// that in_ready is a pure register output. Counts issued immediates.
module imm_issue_ctrl
  import wisc_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  imm_issue_ctrl_if.slave  bus,
  output logic [CNT_W-1:0] imm_cnt,
  output state_t           dbg_state
);

  logic        dec_used;
  logic        dec_ext;
  logic [1:0]  dec_len;
  logic [15:0] in_imm;
  slot_t       in_slot;
  slot_t       main_q;
  slot_t       skid_q;
  state_t      state_q;
  state_t      state_d;
  logic        in_ready_q;
  logic        acc;
  logic        dq;
  logic        ld_main_in;
  logic        ld_main_skid;
  logic        ld_skid_in;

  imm_decode u_decode (
    .opcode   (bus.in_instr[15:11]),
    .used     (dec_used),
    .ext_type (dec_ext),
    .length   (dec_len)
  );

  extender u_extender (
    .field    (bus.in_instr[10:0]),
    .used     (dec_used),
    .ext_type (dec_ext),
    .length   (dec_len),
    .imm      (in_imm)
  );

  assign in_slot = {bus.in_instr, bus.in_pc, in_imm, dec_used};

  assign acc = bus.in_valid & in_ready_q;
  assign dq  = bus.out_valid & bus.out_ready;

  // Next-state and slot-load decode; flush overrides every other event.
  always_comb begin
    state_d      = state_q;
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid_in   = 1'b0;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (acc) begin
            state_d    = ST_ONE;
            ld_main_in = 1'b1;
          end
        end
        ST_ONE: begin
          if (acc && !dq) begin
            state_d    = ST_TWO;
            ld_skid_in = 1'b1;
          end else if (!acc && dq) begin
            state_d = ST_EMPTY;
          end else if (acc && dq) begin
            ld_main_in = 1'b1;
          end
        end
        ST_TWO: begin
          // in_ready is low here, so only a dequeue can happen.
          if (dq) begin
            state_d      = ST_ONE;
            ld_main_skid = 1'b1;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

  // State register; in_ready is precomputed from the next state so fetch
  // never sees a combinational path through out_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != ST_TWO);
    end
  end

  // Main and skid data registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (ld_main_in) begin
        main_q <= in_slot;
      end else if (ld_main_skid) begin
        main_q <= skid_q;
      end
      if (ld_skid_in) begin
        skid_q <= in_slot;
      end
    end
  end

  // Saturating count of issued immediates; flush clears it even when a
  // dequeue happens in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imm_cnt <= '0;
    end else if (flush) begin
      imm_cnt <= '0;
    end else if (dq && main_q.used && (imm_cnt != {CNT_W{1'b1}})) begin
      imm_cnt <= imm_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.out_valid    = (state_q != ST_EMPTY);
  assign bus.out_instr    = main_q.instr;
  assign bus.out_pc       = main_q.pc;
  assign bus.out_imm      = main_q.imm;
  assign bus.out_imm_used = main_q.used;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_imm_issue_ctrl.sv
// Testbench for imm_issue_ctrl: directed scenarios plus a randomized stream
// checked against a queue-based reference model of the buffer and counter.
module tb_imm_issue_ctrl;
  import wisc_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        flush;
  logic        flush2;
  logic [15:0] imm_cnt;
  logic [1:0]  imm_cnt2;
  state_t      dbg_state;
  state_t      dbg_state2;

  imm_issue_ctrl_if bus ();
  imm_issue_ctrl_if bus2 ();

  imm_issue_ctrl #(.CNT_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .bus       (bus),
    .imm_cnt   (imm_cnt),
    .dbg_state (dbg_state)
  );

  imm_issue_ctrl #(.CNT_W(2)) dut_sat (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush2),
    .bus       (bus2),
    .imm_cnt   (imm_cnt2),
    .dbg_state (dbg_state2)
  );

  // ---------------- scoreboard / model ----------------
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [48:0] exp_q[$];      // {instr, pc, imm, used}, oldest first
  logic [15:0] exp_cnt;

  // Immediate as the ISA table defines it: {used, value}.
  function automatic logic [16:0] ref_imm(input logic [15:0] ins);
    int len;
    bit sgn;
    int field;
    int val;
    len = 0;
    sgn = 1'b0;
    case (ins[15:11])
      5'b01000, 5'b01001, 5'b10000, 5'b10001, 5'b10011: begin len = 5; sgn = 1'b1; end
      5'b01010, 5'b01011, 5'b10100, 5'b10101, 5'b10110, 5'b10111: len = 5;
      5'b01100, 5'b01101, 5'b01110, 5'b01111, 5'b11000, 5'b00101, 5'b00111: begin
        len = 8; sgn = 1'b1;
      end
      5'b10010: len = 8;
      5'b00100, 5'b00110: begin len = 11; sgn = 1'b1; end
      default: len = 0;
    endcase
    if (len == 0) return 17'h0;
    field = int'(ins) % (1 << len);
    val   = field;
    if (sgn && field >= (1 << (len - 1))) val = field - (1 << len);
    return {1'b1, 16'(val)};
  endfunction

  function automatic logic [48:0] make_entry(input logic [15:0] ins, input logic [15:0] pc);
    logic [16:0] r;
    r = ref_imm(ins);
    return {ins, pc, r[15:0], r[16]};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic apply(input logic v, input logic [15:0] ins, input logic [15:0] pc,
                       input logic ordy, input logic fl);
    bus.in_valid  = v;
    bus.in_instr  = ins;
    bus.in_pc     = pc;
    bus.out_ready = ordy;
    flush         = fl;
  endtask

  // Update the model for the coming edge, then move to 1 time unit past it.
  task automatic advance();
    bit          m_acc;
    bit          m_dq;
    logic [48:0] e;
    m_acc = bus.in_valid && (exp_q.size() < 2);
    m_dq  = bus.out_ready && (exp_q.size() > 0);
    if (flush) begin
      exp_q.delete();
      exp_cnt = 16'h0;
    end else begin
      if (m_dq) begin
        e = exp_q.pop_front();
        if (e[0] && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'h1;
      end
      if (m_acc) exp_q.push_back(make_entry(bus.in_instr, bus.in_pc));
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    apply(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    bus2.in_valid = 1'b0; bus2.in_instr = 16'h0; bus2.in_pc = 16'h0; bus2.out_ready = 1'b0;
    flush2 = 1'b0;
    exp_q.delete();
    exp_cnt = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    n_tests++; if (imm_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_imm_cnt: got %h want 0000", imm_cnt); end
    n_tests++; if ({bus.out_instr, bus.out_pc, bus.out_imm} !== 48'h0) begin
      n_fail++; $display("FAIL reset_out_data: got %h %h %h want zeros", bus.out_instr, bus.out_pc, bus.out_imm);
    end
    n_tests++; if (bus.out_imm_used !== 1'b0) begin n_fail++; $display("FAIL reset_imm_used: got %b want 0", bus.out_imm_used); end
    n_tests++; if (dbg_state !== ST_EMPTY || dbg_state2 !== ST_EMPTY) begin
      n_fail++; $display("FAIL reset_state: got %0d/%0d want 0", dbg_state, dbg_state2);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_addi();
    apply(1'b1, 16'h401F, 16'h0102, 1'b1, 1'b0);
    n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL addi_in_ready: got %b want 1", bus.in_ready); end
    advance();
    apply(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
    n_tests++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL addi_valid: got %b want 1", bus.out_valid); end
    n_tests++; if (bus.out_imm !== 16'hFFFF) begin n_fail++; $display("FAIL addi_imm: got %h want ffff", bus.out_imm); end
    n_tests++; if (bus.out_imm_used !== 1'b1) begin n_fail++; $display("FAIL addi_used: got %b want 1", bus.out_imm_used); end
    n_tests++; if ({bus.out_instr, bus.out_pc} !== {16'h401F, 16'h0102}) begin
      n_fail++; $display("FAIL addi_word: got %h %h want 401f 0102", bus.out_instr, bus.out_pc);
    end
    advance();
    n_tests++; if (imm_cnt !== 16'h1) begin n_fail++; $display("FAIL addi_cnt: got %h want 0001", imm_cnt); end
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL addi_drained: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] ins [3];
    logic [15:0] want[3];
    ins  = '{16'h501F, 16'h9080, 16'h2400};   // XORI, SLBI, J
    want = '{16'h001F, 16'h0080, 16'hFC00};
    for (int i = 0; i < 4; i++) begin
      if (i < 3) apply(1'b1, ins[i], 16'h0200 + 16'(2 * i), 1'b1, 1'b0);
      else       apply(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
      if (i > 0) begin
        n_tests++; if (bus.out_valid !== 1'b1 || bus.out_imm !== want[i-1]) begin
          n_fail++; $display("FAIL b2b_imm%0d: got v=%b %h want v=1 %h", i - 1, bus.out_valid, bus.out_imm, want[i-1]);
        end
      end
      n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready%0d: got %b want 1", i, bus.in_ready); end
      advance();
    end
    n_tests++; if (imm_cnt !== exp_cnt) begin n_fail++; $display("FAIL b2b_cnt: got %h want %h", imm_cnt, exp_cnt); end
  endtask

  task automatic test_stall();
    logic [15:0] w[3];
    logic [15:0] p[3];
    w = '{16'h4001, 16'h4802, 16'h8003};
    p = '{16'h0A00, 16'h0A02, 16'h0A04};
    apply(1'b1, w[0], p[0], 1'b0, 1'b0);
    n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_rdy0: got %b want 1", bus.in_ready); end
    advance();
    apply(1'b1, w[1], p[1], 1'b0, 1'b0);
    n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_rdy1: got %b want 1", bus.in_ready); end
    advance();
    for (int k = 0; k < 2; k++) begin
      apply(1'b1, w[2], p[2], 1'b0, 1'b0);
      n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_rdy_full%0d: got %b want 0", k, bus.in_ready); end
      n_tests++; if (bus.out_instr !== w[0] || bus.out_pc !== p[0]) begin
        n_fail++; $display("FAIL stall_hold%0d: got %h %h want %h %h", k, bus.out_instr, bus.out_pc, w[0], p[0]);
      end
      advance();
    end
    n_tests++; if (dbg_state !== ST_TWO) begin n_fail++; $display("FAIL stall_state: got %0d want 2", dbg_state); end
    for (int k = 0; k < 3; k++) begin
      apply(k < 2, w[2], p[2], 1'b1, 1'b0);
      n_tests++; if (bus.out_valid !== 1'b1 || bus.out_instr !== w[k] || bus.out_pc !== p[k]) begin
        n_fail++; $display("FAIL stall_order%0d: got v=%b %h %h want v=1 %h %h", k, bus.out_valid, bus.out_instr, bus.out_pc, w[k], p[k]);
      end
      advance();
    end
    apply(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_empty: got %b want 0", bus.out_valid); end
    n_tests++; if (imm_cnt !== exp_cnt) begin n_fail++; $display("FAIL stall_cnt: got %h want %h", imm_cnt, exp_cnt); end
  endtask

  task automatic test_flush();
    apply(1'b1, 16'h4005, 16'h0C00, 1'b0, 1'b0);
    advance();
    apply(1'b1, 16'h6010, 16'h0C02, 1'b0, 1'b0);
    advance();
    apply(1'b1, 16'hBEEF, 16'h0F00, 1'b0, 1'b1);
    n_tests++; if (bus.in_ready !== 1'b0 || imm_cnt !== exp_cnt) begin
      n_fail++; $display("FAIL flush_pre: got rdy=%b cnt=%h want rdy=0 cnt=%h", bus.in_ready, imm_cnt, exp_cnt);
    end
    advance();
    // Offer a word while flushing from EMPTY: it must be dropped too.
    apply(1'b1, 16'h4111, 16'h0F02, 1'b1, 1'b1);
    n_tests++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || imm_cnt !== 16'h0) begin
      n_fail++; $display("FAIL flush_post: got v=%b rdy=%b cnt=%h want v=0 rdy=1 cnt=0000", bus.out_valid, bus.in_ready, imm_cnt);
    end
    advance();
    for (int k = 0; k < 3; k++) begin
      apply(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
      n_tests++; if (bus.out_valid !== 1'b0) begin
        n_fail++; $display("FAIL flush_dropped%0d: got v=%b instr=%h want v=0", k, bus.out_valid, bus.out_instr);
      end
      advance();
    end
  endtask

  task automatic test_non_imm();
    logic [15:0] cnt_before;
    cnt_before = exp_cnt;
    apply(1'b1, 16'hD8A5, 16'h0300, 1'b1, 1'b0);
    advance();
    apply(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
    n_tests++; if (bus.out_valid !== 1'b1 || bus.out_instr !== 16'hD8A5) begin
      n_fail++; $display("FAIL nonimm_word: got v=%b %h want v=1 d8a5", bus.out_valid, bus.out_instr);
    end
    n_tests++; if (bus.out_imm !== 16'h0 || bus.out_imm_used !== 1'b0) begin
      n_fail++; $display("FAIL nonimm_imm: got %h used=%b want 0000 used=0", bus.out_imm, bus.out_imm_used);
    end
    advance();
    n_tests++; if (imm_cnt !== cnt_before) begin n_fail++; $display("FAIL nonimm_cnt: got %h want %h", imm_cnt, cnt_before); end
  endtask

  task automatic test_saturation();
    logic [1:0] want[4];
    want = '{2'd1, 2'd2, 2'd3, 2'd3};
    apply(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
    n_tests++; if (imm_cnt2 !== 2'd0) begin n_fail++; $display("FAIL sat_start: got %0d want 0", imm_cnt2); end
    bus2.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus2.in_valid = (i < 4);
      bus2.in_instr = 16'h4001 + 16'(i);
      bus2.in_pc    = 16'h0500 + 16'(2 * i);
      @(posedge clk);
      #1;
      if (i > 0) begin
        n_tests++; if (imm_cnt2 !== want[i-1]) begin n_fail++; $display("FAIL sat_cnt%0d: got %0d want %0d", i - 1, imm_cnt2, want[i-1]); end
      end
    end
    bus2.in_valid = 1'b0;
    flush2 = 1'b1;
    @(posedge clk);
    #1;
    flush2 = 1'b0;
    n_tests++; if (imm_cnt2 !== 2'd0) begin n_fail++; $display("FAIL sat_flush: got %0d want 0", imm_cnt2); end
  endtask

  task automatic test_random();
    logic [48:0] got;
    bit          ordy;
    for (int c = 0; c < 600; c++) begin
      // Alternate phases of eager and stalling downstream.
      ordy = ((c / 60) % 2 == 0) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 2) == 0);
      apply($urandom_range(0, 3) != 0, 16'($urandom), 16'($urandom), ordy, $urandom_range(0, 59) == 0);
      n_tests++; if (bus.in_ready !== (exp_q.size() < 2)) begin
        n_fail++; $display("FAIL rand_in_ready@%0d: got %b want %b", c, bus.in_ready, exp_q.size() < 2);
      end
      n_tests++; if (bus.out_valid !== (exp_q.size() > 0)) begin
        n_fail++; $display("FAIL rand_out_valid@%0d: got %b want %b", c, bus.out_valid, exp_q.size() > 0);
      end
      n_tests++; if (imm_cnt !== exp_cnt) begin n_fail++; $display("FAIL rand_cnt@%0d: got %h want %h", c, imm_cnt, exp_cnt); end
      if (exp_q.size() > 0) begin
        got = {bus.out_instr, bus.out_pc, bus.out_imm, bus.out_imm_used};
        n_tests++; if (got !== exp_q[0]) begin
          n_fail++; $display("FAIL rand_data@%0d: got %h want %h", c, got, exp_q[0]);
        end
      end
      advance();
    end
  endtask

  task automatic test_async_reset();
    apply(1'b1, 16'h4003, 16'h0700, 1'b0, 1'b0);
    advance();
    apply(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    n_tests++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL arst_setup: got %b want 1", bus.out_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || imm_cnt !== 16'h0) begin
      n_fail++; $display("FAIL arst_immediate: got v=%b rdy=%b cnt=%h want v=0 rdy=1 cnt=0000", bus.out_valid, bus.in_ready, imm_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    exp_cnt = 16'h0;
    @(posedge clk);
    #1;
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_after: got %b want 0", bus.out_valid); end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_addi();
    test_back_to_back();
    test_stall();
    test_flush();
    test_non_imm();
    test_saturation();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/imm_issue_ctrl.md
# imm_issue_ctrl

- Decode-stage controller that accepts 16-bit instructions from fetch over a valid/ready handshake.
- Derives the immediate-extension controls from the opcode (sign/zero, 5/8/11-bit field).
- Drives the `extender` datapath and presents instruction, PC and extended immediate to the register-read stage.
- Buffers through a 2-entry skid so fetch never sees a combinational ready path; supports pipeline flush and counts issued immediates.

## Interface
Parameters:
- CNT_W, 16, width of the saturating issued-immediate counter.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous squash of all buffered instructions.
- in_valid  in  1  fetch has an instruction.
- in_ready  out  1  controller can accept; registered.
- in_instr  in  16  instruction word.
- in_pc  in  16  PC+2 of the instruction.
- out_valid  out  1  output slot holds an instruction.
- out_ready  in  1  downstream accepts.
- out_instr  out  16  buffered instruction.
- out_pc  out  16  buffered PC.
- out_imm  out  16  extended immediate; 0 when unused.
- out_imm_used  out  1  instruction carries an immediate.
- imm_cnt  out  CNT_W  immediates issued since reset or flush; saturates at all-ones.

## Operation
- Opcode is in_instr[15:11].
- Decode from opcode to {used, ext_type, length}; ext_type 1 = sign, 0 = zero; length 00 = 5-bit, 01 = 8-bit, 10 = 11-bit.
  - 01000, 01001, 10000, 10001, 10011: used, sign, 5-bit.
  - 01010, 01011, 10100–10111: used, zero, 5-bit.
  - 01100–01111, 11000, 00101, 00111: used, sign, 8-bit.
  - 10010: used, zero, 8-bit.
  - 00100, 00110: used, sign, 11-bit.
  - All other opcodes: used = 0, out_imm = 0.
- Field wiring: 5-bit field = instr[4:0], 8-bit field = instr[7:0], 11-bit field = instr[10:0].
- Extension is performed at the input, before capture; the main and skid registers hold instr, pc, imm and used.
- Skid FSM states:
  - EMPTY (nothing held).
  - ONE (main register valid).
  - TWO (main and skid valid).
- Transitions (acc = in_valid & in_ready, dq = out_valid & out_ready):
  - EMPTY: on acc, go to ONE.
  - ONE: acc & !dq goes to TWO (new word into skid); !acc & dq goes to EMPTY; acc & dq stays ONE with main replaced by the new word.
  - TWO: dq goes to ONE, with skid moved into main. in_ready is 0 in TWO, so acc cannot occur.
- Outputs:
  - in_ready = (state != TWO), registered as the next-state decode.
  - out_valid = (state != EMPTY).
- imm_cnt increments by 1 on every dq with out_imm_used = 1 and holds at 2^CNT_W−1.
- Flush has priority over every other event in the same cycle:
  - State goes to EMPTY and imm_cnt clears.
  - A concurrent input is dropped.
  - A concurrent dequeue still counts as delivered downstream, but imm_cnt is cleared anyway.
- Reset mid-operation: any buffered contents are discarded immediately, asynchronously.

## Timing
- Reset values:
  - in_ready = 1, out_valid = 0, imm_cnt = 0.
  - out_instr, out_pc, out_imm = 16'h0000; out_imm_used = 0.
- Latency: a word accepted in cycle N appears on out_* in cycle N+1 when the buffer was EMPTY, or when it was ONE and dequeued in cycle N.
- Throughput: 1 instruction/cycle while out_ready is held at 1.
- Ordering is strictly FIFO.
- out_* are stable while out_valid = 1 and out_ready = 0.
- in_ready drops the cycle after the second word is held. No word is lost: the skid absorbs the word accepted in that same cycle.
- After flush, in_ready = 1 and out_valid = 0 on the next cycle.

## Structure
- Shared package `wisc_pkg` holds:
  - opcode localparams (ADDI, SUBI, …, JAL).
  - LEN_5 = 2'b00, LEN_8 = 2'b01, LEN_11 = 2'b10.
  - EXT_SIGN = 1'b1, EXT_ZERO = 1'b0.
  - state encodings ST_EMPTY = 2'b00, ST_ONE = 2'b01, ST_TWO = 2'b10.
- Natural sub-module: `imm_decode`, combinational, mapping opcode to {used, ext_type, length}.
- `extender` is instantiated once, on the input side.
- Top level holds the skid FSM, the data registers and the counter.

## Test plan
- Reset, then ADDI with instr = 16'h4_01F (imm5 = 11111) and out_ready = 1:
  - next cycle out_imm = 16'hFFFF, out_imm_used = 1, imm_cnt = 1 after the dequeue.
- Stream XORI (imm5 = 5'h1F), SLBI (imm8 = 8'h80), J (imm11 = 11'h400) back-to-back with out_ready = 1:
  - out_imm sequence 16'h001F, 16'h0080, 16'hFC00, one per cycle.
- Hold out_ready = 0 and offer 3 words:
  - first two accepted, in_ready = 0 from the cycle after the second accept, third held at the input.
  - then raise out_ready: all three emerge in order.
- Assert flush while in TWO with in_valid = 1:
  - next cycle out_valid = 0, in_ready = 1, imm_cnt = 0; the offered word never appears.
- Non-immediate opcode (ADD, 11011):
  - out_imm = 0, out_imm_used = 0, imm_cnt unchanged.
- Preload imm_cnt near saturation (CNT_W = 2) with 4 ADDIs:
  - imm_cnt reads 1, 2, 3, 3.
- Assert rst_n low mid-stream between clock edges:
  - out_valid drops immediately.
